jram_burst: RTL and testbench

JRAM_BURST -- requirements
Module: jram_burst

---
 rtl/jram_burst.sv | 119 +++++++++++
 tb/tb_jram_burst.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jram_burst.sv
// Single-port RAM with a memory address register (MAR), single-word read/write
// access and an auto-incrementing burst engine (read bursts or bvalid-paced write bursts).
module jram_burst #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 8,
    parameter int LWIDTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] bas,
    input  logic              wsa,
    input  logic [WIDTH-1:0]  bis,
    input  logic              ws,
    input  logic              we,
    input  logic              bstart,
    input  logic              bwrite,
    input  logic [LWIDTH-1:0] blen,
    input  logic              bvalid,
    output logic [WIDTH-1:0]  bos,
    output logic              rvalid,
    output logic              busy,
    output logic              done
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [LWIDTH:0] MAX_BEATS = {1'b1, {LWIDTH{1'b0}}};
    localparam logic [LWIDTH:0] ONE_BEAT  = (LWIDTH+1)'(1);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] mar_q, mar_d;
    logic [LWIDTH:0]   cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic              rvalid_q, rvalid_d;
    logic              done_q, done_d;

    logic [AWIDTH-1:0] ram_addr;
    logic              ram_we;
    logic              ram_re;
    logic [WIDTH-1:0]  mem [2**AWIDTH];
    logic [WIDTH-1:0]  rd_q;

    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        rvalid_d = 1'b0;
        done_d   = 1'b0;
        ram_addr = mar_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        case (state_q)
            IDLE: begin
                // A same-cycle address load steers the access to the new address.
                if (wsa) begin
                    mar_d    = bas;
                    ram_addr = bas;
                end
                ram_we   = ws;
                ram_re   = we;
                rvalid_d = we;
                if (bstart) begin
                    state_d = BURST;
                    dir_d   = bwrite;
                    cnt_d   = (blen == '0) ? MAX_BEATS : {1'b0, blen};
                end
            end
            BURST: begin
                // Reads run every cycle; writes only advance on a qualified beat.
                if (!dir_q || bvalid) begin
                    ram_we   = dir_q;
                    ram_re   = !dir_q;
                    rvalid_d = !dir_q;
                    mar_d    = mar_q + AWIDTH'(1);
                    cnt_d    = cnt_q - ONE_BEAT;
                    if (cnt_q == ONE_BEAT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mar_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mar_q    <= mar_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
        end
    end

    // Read-first RAM: a simultaneous write returns the old word. No reset on contents.
    always_ff @(posedge clk) begin
        if (ram_re) begin
            rd_q <= mem[ram_addr];
        end
        if (ram_we && reset_n) begin
            mem[ram_addr] <= bis;
        end
    end

    assign bos    = rvalid_q ? rd_q : '0;
    assign rvalid = rvalid_q;
    assign busy   = (state_q == BURST);
    assign done   = done_q;

endmodule

// File: tb/tb_jram_burst.sv
// Scoreboard bench for jram_burst: a transaction-level memory model predicts read
// data and done pulses; a monitor checks every cycle after the rising edge.
module tb_jram_burst;
    localparam int WIDTH  = 8;
    localparam int AWIDTH = 8;
    localparam int LWIDTH = 4;
    localparam int DEPTH  = 256;
    localparam int MAXB   = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [AWIDTH-1:0] bas;
    logic              wsa;
    logic [WIDTH-1:0]  bis;
    logic              ws;
    logic              we;
    logic              bstart;
    logic              bwrite;
    logic [LWIDTH-1:0] blen;
    logic              bvalid;
    logic [WIDTH-1:0]  bos;
    logic              rvalid;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    jram_burst #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .LWIDTH(LWIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .bas(bas), .wsa(wsa), .bis(bis), .ws(ws),
        .we(we), .bstart(bstart), .bwrite(bwrite), .blen(blen), .bvalid(bvalid),
        .bos(bos), .rvalid(rvalid), .busy(busy), .done(done)
    );

    typedef struct {
        logic [7:0] data;
        bit         known;
    } rd_exp_t;

    rd_exp_t    rd_exp[$];
    bit         done_exp[$];
    logic [7:0] m_mem[DEPTH];
    bit         m_known[DEPTH];
    int         m_mar;
    bit         m_burst;
    bit         m_dir;
    int         m_left;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic idle_inputs();
        wsa = 0; ws = 0; we = 0; bstart = 0; bwrite = 0; bvalid = 0;
        blen = '0; bas = '0; bis = '0;
    endtask

    // Behavioural memory: what one clock edge does to MAR, memory and the burst.
    task automatic model_edge();
        int a;
        if (!m_burst) begin
            a = wsa ? int'(bas) : m_mar;
            m_mar = a;
            if (we) rd_exp.push_back('{data: m_mem[a], known: m_known[a]});
            if (ws) begin
                m_mem[a] = bis;
                m_known[a] = 1;
            end
            if (bstart) begin
                m_burst = 1;
                m_dir   = bwrite;
                m_left  = (blen == 0) ? MAXB : int'(blen);
            end
        end else if (!m_dir || bvalid) begin
            if (m_dir) begin
                m_mem[m_mar] = bis;
                m_known[m_mar] = 1;
            end else begin
                rd_exp.push_back('{data: m_mem[m_mar], known: m_known[m_mar]});
            end
            m_mar = (m_mar + 1) % DEPTH;
            m_left--;
            if (m_left == 0) begin
                m_burst = 0;
                done_exp.push_back(1'b1);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        idle_inputs(); wsa = 1; bas = a; ws = 1; bis = d;
        step();
    endtask

    task automatic rd(input logic [7:0] a);
        idle_inputs(); wsa = 1; bas = a; we = 1;
        step();
    endtask

    task automatic rd_here();
        idle_inputs(); we = 1;
        step();
    endtask

    task automatic pulse_reset();
        reset_n = 0;
        m_mar   = 0;
        m_burst = 0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rvalid", rvalid, 0);
        @(posedge clk);
        #2;
        reset_n = 1;
    endtask

    always @(posedge clk) begin
        rd_exp_t e;
        #1;
        if (reset_n) begin
            chk("busy", busy, m_burst);
            if (rd_exp.size() > 0) begin
                e = rd_exp.pop_front();
                chk("rvalid", rvalid, 1);
                if (e.known) chk("bos", bos, e.data);
            end else begin
                chk("rvalid_idle", rvalid, 0);
                chk("bos_idle", bos, 0);
            end
            if (done_exp.size() > 0) begin
                void'(done_exp.pop_front());
                chk("done", done, 1);
            end else begin
                chk("done_idle", done, 0);
            end
        end
    end

    initial begin
        idle_inputs();
        m_mar = 0; m_burst = 0; m_dir = 0; m_left = 0;
        foreach (m_known[i]) m_known[i] = 0;
        foreach (m_mem[i]) m_mem[i] = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_bos", bos, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset_n = 1;

        // Address load, write, read, then the idle cycle after the read.
        idle_inputs(); wsa = 1; bas = 8'h12; step();
        idle_inputs(); ws = 1; bis = 8'hA5; step();
        rd_here();
        idle_inputs(); step(); step();

        // Simultaneous write and read returns the old word.
        idle_inputs(); ws = 1; we = 1; bis = 8'h3C; step();
        rd_here();
        idle_inputs(); step();

        wr(8'h02, 8'h77);
        wr(8'h10, 8'h99);

        // Wrapping write burst from 0xFE with one stall after beat 2.
        idle_inputs(); wsa = 1; bas = 8'hFE; step();
        idle_inputs(); bstart = 1; bwrite = 1; blen = 4'd4; step();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            if (i != 2) begin
                bvalid = 1;
                bis = (i < 2) ? 8'(i + 1) : 8'(i);
            end
            step();
        end
        rd_here();
        idle_inputs(); step();

        // Wrapping read burst from 0xFE, then MAR should sit at 0x02.
        idle_inputs(); wsa = 1; bas = 8'hFE; step();
        idle_inputs(); bstart = 1; bwrite = 0; blen = 4'd4; step();
        for (int i = 0; i < 4; i++) begin idle_inputs(); step(); end
        rd_here();
        idle_inputs(); step();

        // blen=0 means a full 16-beat burst; address loaded with bstart.
        for (int i = 0; i < 16; i++) wr(8'(i), 8'(i) ^ 8'h5A);
        idle_inputs(); wsa = 1; bas = 8'h00; bstart = 1; blen = 4'd0; step();
        for (int i = 0; i < 16; i++) begin idle_inputs(); step(); end
        rd_here();
        idle_inputs(); step();

        // Control inputs toggled during a read burst must be ignored.
        for (int i = 0; i < 4; i++) wr(8'h20 + 8'(i), 8'hB0 + 8'(i));
        wr(8'h30, 8'h11);
        idle_inputs(); wsa = 1; bas = 8'h20; bstart = 1; blen = 4'd4; step();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            wsa = 1; bas = 8'h30; ws = 1; we = 1; bis = 8'hEE; bstart = 1; blen = 4'd2;
            step();
        end
        idle_inputs(); step();
        rd(8'h30);
        rd_here();
        idle_inputs(); step();

        // Reset in the middle of a 4-beat write burst.
        for (int i = 0; i < 4; i++) wr(8'h40 + 8'(i), 8'hC0 + 8'(i));
        idle_inputs(); wsa = 1; bas = 8'h40; bstart = 1; bwrite = 1; blen = 4'd4; step();
        idle_inputs(); bvalid = 1; bis = 8'hD1; step();
        idle_inputs(); bvalid = 1; bis = 8'hD2; step();
        idle_inputs(); bvalid = 1; bis = 8'hD3;
        pulse_reset();
        idle_inputs(); step(); step();
        rd_here();
        for (int i = 0; i < 4; i++) rd(8'h40 + 8'(i));
        idle_inputs(); step();

        // Randomised mix of single accesses and bursts.
        repeat (60) begin
            case ($urandom_range(0, 3))
                0: wr(8'($urandom), 8'($urandom));
                1: rd(8'($urandom));
                2: begin
                    idle_inputs(); wsa = 1; bas = 8'($urandom); ws = 1; we = 1; bis = 8'($urandom);
                    step();
                end
                default: begin
                    idle_inputs();
                    wsa = 1; bas = 8'($urandom); bstart = 1;
                    bwrite = 1'($urandom); blen = 4'($urandom);
                    step();
                    for (int g = 0; g < 200 && m_burst; g++) begin
                        idle_inputs();
                        bvalid = (g >= 100) ? 1'b1 : 1'($urandom);
                        bis = 8'($urandom);
                        wsa = 1'($urandom); ws = 1'($urandom); we = 1'($urandom);
                        bstart = 1'($urandom); bas = 8'($urandom);
                        step();
                    end
                end
            endcase
            idle_inputs();
            if ($urandom_range(0, 1) == 1) step();
        end

        idle_inputs(); step(); step();
        chk("rd_queue_empty", rd_exp.size(), 0);
        chk("done_queue_empty", done_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
